crossbar_master_port: RTL and testbench

Master-side (initiator) port of the 4-way crossbar: one instance sits between each local master and its req/gnt pair on the round-robin bus arbiter. It buffers outgoing words in a small FIFO and, on a transfer command, raises `req` and waits for `gnt`. Once granted it streams the burst onto the shared bus, holding `req` for the whole burst so the arbiter keeps the bus locked. It then drops `req` and waits for `gnt` to clear before accepting the next command.

---
 rtl/crossbar_master_port.sv | 141 ++++++++++++++
 tb/tb_crossbar_master_port.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_master_port.sv
// Initiator port of the 4-way crossbar: FIFO-buffered writes, burst transfer under arbiter req/gnt.
// Optional grant-wait timeout in REQ is enabled by defining CROSSBAR_GNT_TIMEOUT_EN.
module crossbar_master_port #(
  parameter int DW      = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [DW-1:0]              wr_data_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [$clog2(DEPTH+1)-1:0] cmd_len_i,
  output logic                       req_o,
  input  logic                       gnt_i,
  output logic                       bus_valid_o,
  output logic [DW-1:0]              bus_data_o,
  output logic                       bus_last_o,
  output logic                       busy_o,
  output logic                       err_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
  output logic [1:0]                 state_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("crossbar_master_port: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_REL} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_last_q, bus_last_d;
  logic [DW-1:0]     bus_data_q, bus_data_d;
  logic              err_q, err_d;
  logic [CW-1:0]     beats_q, beats_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [DW-1:0]     mem_q [DEPTH];

  logic push, pop, load, abort, cmd_fire, cmd_bad, timeout_hit;

  // Handshakes: a write or command transfers on the edge where its valid and ready are both high;
  // ready never depends on the matching valid.
  assign wr_ready_o  = count_q < CW'(DEPTH);
  assign cmd_ready_o = (state_q == S_IDLE);
  assign push        = wr_valid_i && wr_ready_o;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign cmd_bad     = (cmd_len_i == '0) || (cmd_len_i > count_q);

  // A beat is loaded on the grant edge and on every granted XFER edge until the last beat is out.
  assign load  = (state_q == S_REQ && gnt_i) || (state_q == S_XFER && gnt_i && !bus_last_q);
  assign abort = (state_q == S_XFER) && !gnt_i && !bus_last_q;
  assign pop   = load;

`ifdef CROSSBAR_GNT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign timeout_hit = (state_q == S_REQ) && !gnt_i && (tmo_q == TW'(TIMEOUT - 1));
  assign tmo_d       = (state_q == S_REQ && !gnt_i) ? tmo_q + TW'(1) : '0;
  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_last_q  <= 1'b0;
      bus_data_q  <= '0;
      err_q       <= 1'b0;
      beats_q     <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      bus_valid_q <= bus_valid_d;
      bus_last_q  <= bus_last_d;
      bus_data_q  <= bus_data_d;
      err_q       <= err_d;
      beats_q     <= beats_d;
      count_q     <= count_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_fire && !cmd_bad) state_d = S_REQ;
      S_REQ:   if (gnt_i) state_d = S_XFER;
               else if (timeout_hit) state_d = S_REL;
      S_XFER:  if (bus_last_q || !gnt_i) state_d = S_REL;
      S_REL:   if (!gnt_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_d       = (state_d == S_REQ) || (state_d == S_XFER);
    bus_valid_d = load;
    bus_last_d  = load && (beats_q == CW'(1));
    bus_data_d  = load ? mem_q[rd_ptr_q] : bus_data_q;
    err_d       = (cmd_fire && cmd_bad) || abort || timeout_hit;
    beats_d     = beats_q;
    if (cmd_fire && !cmd_bad) beats_d = cmd_len_i;
    else if (load)            beats_d = beats_q - CW'(1);
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign req_o        = req_q;
  assign bus_valid_o  = bus_valid_q;
  assign bus_last_o   = bus_last_q;
  assign bus_data_o   = bus_data_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != S_IDLE);
  assign fifo_count_o = count_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_crossbar_master_port.sv
// Randomized bench for crossbar_master_port: queue model of the FIFO, delayed-grant arbiter responder.
module tb_crossbar_master_port;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int TIMEOUT = 16;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk, reset;
  logic wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic cmd_valid, cmd_ready;
  logic [CW-1:0] cmd_len;
  logic req_o, gnt;
  logic bus_valid, bus_last, busy, err;
  logic [DW-1:0] bus_data;
  logic [CW-1:0] fifo_count;
  logic [1:0] state_dbg;

  crossbar_master_port #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len),
    .req_o(req_o), .gnt_i(gnt),
    .bus_valid_o(bus_valid), .bus_data_o(bus_data), .bus_last_o(bus_last),
    .busy_o(busy), .err_o(err), .fifo_count_o(fifo_count), .state_o(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] dir_q[$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, err_cnt = 0;
  int beats_seen = 0, burst_len = 0, abort_at = 0;
  int first_cyc = -1, last_cyc = -1, fall_cyc = -1;
  int push_pct = 0;
  bit hold_low = 0, req_last = 0, push_acc = 0;
  logic [DW-1:0] push_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // one clock: observe outputs after the edge, update the model, then drive the next cycle
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (err) err_cnt++;
    if (req_last && !req_o) fall_cyc = cyc;
    if (bus_valid) begin
      beats_seen++;
      if (beats_seen == 1) first_cyc = cyc;
      last_cyc = cyc;
      check_eq("pop_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_eq("beat_data", bus_data, exp_q.pop_front());
      check_eq("beat_last", bus_last, beats_seen == burst_len);
    end
    if (push_acc) exp_q.push_back(push_word);
    check_eq("fifo_count", fifo_count, exp_q.size());
    // arbiter: grant follows request by one cycle unless the scenario withholds it
    gnt = (hold_low || (abort_at > 0 && beats_seen >= abort_at)) ? 1'b0 : req_last;
    req_last = req_o;
    if (dir_q.size() > 0) begin
      wr_valid = 1'b1;
      wr_data  = dir_q[0];
    end else if (push_pct > 0 && $urandom_range(1, 100) <= push_pct) begin
      wr_valid = 1'b1;
      wr_data  = DW'($urandom);
    end else begin
      wr_valid = 1'b0;
    end
    push_acc  = wr_valid && (exp_q.size() < DEPTH);
    push_word = wr_data;
    if (push_acc && dir_q.size() > 0) void'(dir_q.pop_front());
    check_eq("wr_ready", wr_ready, exp_q.size() < DEPTH);
  endtask

  task automatic push_list(input int n);
    int k;
    for (int i = 0; i < n; i++) dir_q.push_back(DW'($urandom));
    k = 0;
    while (dir_q.size() > 0 && k < 50) begin tick(); k++; end
    check_eq("push_list_done", dir_q.size(), 0);
    tick();
  endtask

  task automatic do_reset();
    wr_valid = 1'b0; push_acc = 1'b0; push_pct = 0; dir_q.delete();
    hold_low = 0; abort_at = 0; req_last = 0; gnt = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    check_eq("rst_req", req_o, 0);
    check_eq("rst_bus_valid", bus_valid, 0);
    check_eq("rst_bus_last", bus_last, 0);
    check_eq("rst_bus_data", bus_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_wr_ready", wr_ready, 1);
  endtask

  task automatic run_burst(input int len, input int abort_cfg);
    int e0, n, acc;
    bit bad;
    bad = (len == 0) || (len > exp_q.size());
    check_eq("cmd_ready_idle", cmd_ready, 1);
    e0 = err_cnt; burst_len = len; beats_seen = 0; abort_at = abort_cfg;
    first_cyc = -1; last_cyc = -1; fall_cyc = -1;
    cmd_valid = 1'b1; cmd_len = CW'(len);
    tick();
    cmd_valid = 1'b0;
    acc = cyc;
    if (bad) begin
      check_eq("bad_req", req_o, 0);
      check_eq("bad_busy", busy, 0);
      tick();
      check_eq("bad_err_pulse", err_cnt - e0, 1);
    end else begin
      n = 0;
      while (busy && n < 100) begin tick(); n++; end
      check_eq("burst_done", busy, 0);
      check_eq("beat_count", beats_seen, (abort_cfg > 0) ? abort_cfg : len);
      check_eq("first_beat_cyc", first_cyc, acc + 2);
      check_eq("beats_contig", last_cyc - first_cyc + 1, beats_seen);
      check_eq("burst_err", err_cnt - e0, (abort_cfg > 0) ? 1 : 0);
      if (abort_cfg == 0) begin
        check_eq("req_fall_cyc", fall_cyc, last_cyc + 1);
        check_eq("idle_return_cyc", cyc, last_cyc + 3);
      end
      check_eq("cmd_ready_after", cmd_ready, 1);
    end
    abort_at = 0;
  endtask

  task automatic top_up();
    push_list(DEPTH - exp_q.size());
  endtask

  initial begin
    int e0, n, len, ab;
    wr_valid = 0; wr_data = '0; cmd_valid = 0; cmd_len = '0; gnt = 0; reset = 1'b1;
    tick();
    do_reset();
    check_eq("rst_fifo_count", fifo_count, 0);

    // three known words, then a len=3 burst
    dir_q.push_back(8'hA1); dir_q.push_back(8'hA2); dir_q.push_back(8'hA3);
    n = 0;
    while (dir_q.size() > 0 && n < 20) begin tick(); n++; end
    tick();
    run_burst(3, 0);
    check_eq("t1_empty", fifo_count, 0);

    // rejected commands
    push_list(2);
    run_burst(4, 0);
    run_burst(0, 0);
    check_eq("t2_count", fifo_count, 2);

    // fill, then push against a full-depth burst
    top_up();
    push_pct = 100;
    tick();
    check_eq("full_no_ready", wr_ready, 0);
    run_burst(DEPTH, 0);
    push_pct = 0;
    tick();

    // grant withdrawn during beat 2 of a len=5 burst
    top_up();
    run_burst(5, 2);
    check_eq("abort_kept", fifo_count, DEPTH - 2);

    // reset in the middle of a transfer
    top_up();
    beats_seen = 0; burst_len = 5;
    cmd_valid = 1'b1; cmd_len = CW'(5);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (beats_seen < 2 && n < 20) begin tick(); n++; end
    check_eq("mid_xfer_reached", beats_seen, 2);
    do_reset();
    check_eq("mid_rst_count", fifo_count, 0);

    // randomized commands against the model
    for (int it = 0; it < 30; it++) begin
      push_list($urandom_range(0, DEPTH - exp_q.size()));
      len = $urandom_range(0, DEPTH);
      ab = (len >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
      push_pct = ($urandom_range(0, 1) == 1) ? 50 : 0;
      run_burst(len, ab);
      push_pct = 0;
      tick();
    end

    // grant never arrives
    top_up();
    e0 = err_cnt; fall_cyc = -1; beats_seen = 0; burst_len = 0;
    hold_low = 1;
    cmd_valid = 1'b1; cmd_len = CW'(3);
    tick();
    cmd_valid = 1'b0;
    n = cyc;
`ifdef CROSSBAR_GNT_TIMEOUT_EN
    begin
      int k;
      k = 0;
      while (busy && k < 100) begin tick(); k++; end
    end
    check_eq("tmo_done", busy, 0);
    check_eq("tmo_req_fall", fall_cyc, n + TIMEOUT);
    check_eq("tmo_err_once", err_cnt - e0, 1);
    check_eq("tmo_count_kept", fifo_count, DEPTH);
`else
    repeat (120) tick();
    check_eq("hold_req", req_o, 1);
    check_eq("hold_busy", busy, 1);
    check_eq("hold_no_err", err_cnt - e0, 0);
    check_eq("hold_count_kept", fifo_count, DEPTH);
`endif
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
